// File: rtl/multitap_pkg.sv
// Multi-tap text entry: shared letter codes, FSM state type, key mapping.
// Build option MULTITAP_BKSP_EN turns key 1 into cancel/backspace.
package multitap_pkg;

  localparam logic [4:0] L_NONE  = 5'd0;
  localparam logic [4:0] L_SPACE = 5'd27;
  localparam logic [4:0] L_BKSP  = 5'd31;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  function automatic logic [4:0] key_base(input logic [3:0] k);
    logic [4:0] b;
    case (k)
      4'd2:    b = 5'd1;
      4'd3:    b = 5'd4;
      4'd4:    b = 5'd7;
      4'd5:    b = 5'd10;
      4'd6:    b = 5'd13;
      4'd7:    b = 5'd16;
      4'd8:    b = 5'd20;
      4'd9:    b = 5'd23;
      default: b = L_NONE;
    endcase
    return b;
  endfunction

  // Highest tap index of the key's group (pqrs and wxyz have four letters).
  function automatic logic [1:0] key_last(input logic [3:0] k);
    return (k == 4'd7 || k == 4'd9) ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [4:0] tap_code(input logic [3:0] k,
                                          input logic [1:0] t);
    return key_base(k) + {3'b000, t};
  endfunction

endpackage

// File: rtl/multitap_fifo.sv
// Output FIFO for committed letters: first-word-fall-through, drops on full
// (unless a pop frees a slot in the same cycle) and pulses o_ovf.
module multitap_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovf;

  logic w_empty;
  logic w_full;
  logic w_rd;
  logic w_wr;
  logic w_drop;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_rd    = i_rd && !w_empty;
  assign w_wr    = i_wr && (!w_full || w_rd);
  assign w_drop  = i_wr && w_full && !w_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      r_ovf <= w_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rp];
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/multitap_entry.sv
// Multi-tap keypad letter entry with timeout commit and output FIFO.
// Build option MULTITAP_BKSP_EN: key 1 cancels pending / enqueues backspace.
module multitap_entry
  import multitap_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int DEPTH          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       pend_valid,
  output logic [4:0] pend_letter,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_letter,
  output logic       overflow
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  logic [3:0]    r_key;
  logic [1:0]    r_tap;
  logic [CW-1:0] r_cnt;
  logic          r_hold_v;
  logic [4:0]    r_hold_code;

  state_t        w_state_nx;
  logic [3:0]    w_key_nx;
  logic [1:0]    w_tap_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_acc;
  logic          w_let;
  logic [4:0]    w_cur;
  logic          w_dir_v;
  logic [4:0]    w_dir_code;
  logic          w_sp;
  logic          w_pend_v;
  logic          w_wr;
  logic [4:0]    w_wcode;
  logic          w_hold_v_nx;
  logic [4:0]    w_hold_code_nx;
  logic          w_ovalid;
  logic [4:0]    w_odata;
  logic          w_ovf;

  assign w_acc = key_valid && (key_code <= 4'd9);
  assign w_let = (key_code >= 4'd2);
  assign w_cur = tap_code(r_key, r_tap);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_key       <= 4'd0;
      r_tap       <= 2'd0;
      r_cnt       <= '0;
      r_hold_v    <= 1'b0;
      r_hold_code <= L_NONE;
    end else begin
      r_state     <= w_state_nx;
      r_key       <= w_key_nx;
      r_tap       <= w_tap_nx;
      r_cnt       <= w_cnt_nx;
      r_hold_v    <= w_hold_v_nx;
      r_hold_code <= w_hold_code_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_key_nx   = r_key;
    w_tap_nx   = r_tap;
    w_cnt_nx   = '0;
    w_dir_v    = 1'b0;
    w_dir_code = w_cur;
    w_sp       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_let) begin
            w_state_nx = S_PEND;
            w_key_nx   = key_code;
            w_tap_nx   = 2'd0;
          end else if (key_code == 4'd0) begin
            w_dir_v    = 1'b1;
            w_dir_code = L_SPACE;
          end
`ifdef MULTITAP_BKSP_EN
          else begin
            w_dir_v    = 1'b1;
            w_dir_code = L_BKSP;
          end
`endif
        end
      end
      S_PEND: begin
        if (w_acc) begin
          if (w_let && key_code == r_key) begin
            w_tap_nx = (r_tap == key_last(r_key)) ? 2'd0 : r_tap + 2'd1;
          end else if (w_let) begin
            w_dir_v  = 1'b1;
            w_key_nx = key_code;
            w_tap_nx = 2'd0;
          end else begin
`ifdef MULTITAP_BKSP_EN
            w_dir_v = (key_code == 4'd0);
`else
            w_dir_v = 1'b1;
`endif
            w_sp       = (key_code == 4'd0);
            w_state_nx = S_IDLE;
          end
        end else if (r_cnt == TLAST) begin
          w_dir_v    = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // A queued second write (space after a letter) always goes out first.
  always_comb begin
    w_pend_v = (r_state == S_PEND);
    if (r_hold_v) begin
      w_wr           = 1'b1;
      w_wcode        = r_hold_code;
      w_hold_v_nx    = w_dir_v;
      w_hold_code_nx = w_dir_code;
    end else begin
      w_wr           = w_dir_v;
      w_wcode        = w_dir_code;
      w_hold_v_nx    = w_sp;
      w_hold_code_nx = L_SPACE;
    end
  end

  multitap_fifo #(
    .DEPTH(DEPTH),
    .W    (5)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_wr   (w_wr),
    .i_wdata(w_wcode),
    .i_rd   (out_ready),
    .o_valid(w_ovalid),
    .o_data (w_odata),
    .o_ovf  (w_ovf)
  );

  assign pend_valid  = rst_n && w_pend_v;
  assign pend_letter = (rst_n && w_pend_v) ? w_cur : L_NONE;
  assign out_valid   = rst_n && w_ovalid;
  assign out_letter  = (rst_n && w_ovalid) ? w_odata : L_NONE;
  assign overflow    = rst_n && w_ovf;

endmodule

// File: tb/tb_multitap_entry.sv
// Randomised + directed bench for multitap_entry against a letter-level
// model (key groups as strings, FIFO and pending writes as queues).
module tb_multitap_entry;

  localparam int T = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       pend_valid;
  logic [4:0] pend_letter;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_letter;
  logic       overflow;

  multitap_entry #(
    .TIMEOUT_CYCLES(T),
    .DEPTH         (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .pend_valid (pend_valid),
    .pend_letter(pend_letter),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_letter (out_letter),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  string groups[10];

  bit m_pend;
  int m_key;
  int m_tap;
  int m_idle;
  bit m_ovf;
  int m_wq[$];
  int m_fifo[$];

  function automatic int letter(int k, int t);
    return int'(groups[k].getc(t)) - 96;
  endfunction

  task automatic expect_eq(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one edge at a time, in terms of letters and queues.
  always @(posedge clk) begin
    bit pop;
    int k;
    int w;
    if (!rst_n) begin
      m_pend = 0;
      m_idle = 0;
      m_ovf  = 0;
      m_wq.delete();
      m_fifo.delete();
    end else begin
      pop   = (m_fifo.size() > 0) && out_ready;
      m_ovf = 0;
      if (key_valid && key_code <= 4'd9) begin
        m_idle = 0;
        k = int'(key_code);
        if (k >= 2) begin
          if (m_pend && k == m_key) begin
            m_tap = (m_tap + 1) % groups[k].len();
          end else begin
            if (m_pend) m_wq.push_back(letter(m_key, m_tap));
            m_pend = 1;
            m_key  = k;
            m_tap  = 0;
          end
        end else if (k == 0) begin
          if (m_pend) m_wq.push_back(letter(m_key, m_tap));
          m_wq.push_back(27);
          m_pend = 0;
        end else begin
`ifdef MULTITAP_BKSP_EN
          if (m_pend) m_pend = 0;
          else m_wq.push_back(31);
`else
          if (m_pend) begin
            m_wq.push_back(letter(m_key, m_tap));
            m_pend = 0;
          end
`endif
        end
      end else if (m_pend) begin
        m_idle++;
        if (m_idle == T) begin
          m_wq.push_back(letter(m_key, m_tap));
          m_pend = 0;
          m_idle = 0;
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (m_wq.size() > 0) begin
        w = m_wq.pop_front();
        if (m_fifo.size() < D) m_fifo.push_back(w);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      expect_eq("pend_valid", 32'(pend_valid), 32'(rst_n && m_pend));
      expect_eq("pend_letter", 32'(pend_letter),
                (rst_n && m_pend) ? letter(m_key, m_tap) : 0);
      expect_eq("out_valid", 32'(out_valid),
                32'(rst_n && m_fifo.size() > 0));
      if (!rst_n) expect_eq("out_letter_rst", 32'(out_letter), 0);
      else if (m_fifo.size() > 0)
        expect_eq("out_letter", 32'(out_letter), m_fifo[0]);
      expect_eq("overflow", 32'(overflow), 32'(rst_n && m_ovf));
    end
  end

  task automatic tick(input bit kv, input logic [3:0] kc, input bit rdy);
    key_valid = kv;
    key_code  = kc;
    out_ready = rdy;
    @(posedge clk);
    #2;
    key_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (14) tick(0, 4'd0, 1);
  endtask

  initial begin
    groups = '{"", "", "abc", "def", "ghi", "jkl", "mno", "pqrs", "tuv",
               "wxyz"};
    rst_n = 0;
    key_valid = 0;
    key_code = 0;
    out_ready = 0;
    @(posedge clk);
    #2;
    chk_en = 1;
    tick(0, 4'd0, 0);
    expect_eq("rst_pend_valid", 32'(pend_valid), 0);
    expect_eq("rst_out_valid", 32'(out_valid), 0);
    rst_n = 1;

    // key 7 x5 then timeout
    tick(1, 4'd7, 0); expect_eq("k7_t1", 32'(pend_letter), 16);
    tick(1, 4'd7, 0); expect_eq("k7_t2", 32'(pend_letter), 17);
    tick(1, 4'd7, 0); expect_eq("k7_t3", 32'(pend_letter), 18);
    tick(1, 4'd7, 0); expect_eq("k7_t4", 32'(pend_letter), 19);
    tick(1, 4'd7, 0); expect_eq("k7_wrap", 32'(pend_letter), 16);
    repeat (T - 1) tick(0, 4'd0, 0);
    expect_eq("k7_before_to", 32'(pend_valid), 1);
    expect_eq("k7_before_out", 32'(out_valid), 0);
    tick(0, 4'd0, 0);
    expect_eq("k7_to_pend", 32'(pend_valid), 0);
    expect_eq("k7_to_out", 32'(out_letter), 16);
    tick(0, 4'd0, 1);
    expect_eq("k7_single", 32'(out_valid), 0);

    // 2,2,3 then timeout
    tick(1, 4'd2, 0);
    tick(1, 4'd2, 0);
    tick(1, 4'd3, 0);
    expect_eq("b_commit", 32'(out_letter), 2);
    expect_eq("d_preview", 32'(pend_letter), 4);
    repeat (T) tick(0, 4'd0, 0);
    expect_eq("bd_head", 32'(out_letter), 2);
    tick(0, 4'd0, 1);
    expect_eq("bd_second", 32'(out_letter), 4);
    tick(0, 4'd0, 1);
    expect_eq("bd_empty", 32'(out_valid), 0);

    // key 4 then space
    tick(1, 4'd4, 0);
    tick(1, 4'd0, 0);
    expect_eq("g_first", 32'(out_letter), 7);
    tick(0, 4'd0, 0);
    tick(0, 4'd0, 1);
    expect_eq("space_second", 32'(out_letter), 27);
    tick(0, 4'd0, 1);
    expect_eq("gs_empty", 32'(out_valid), 0);

    // overflow on fifth commit, then full write + pop
    drain();
    tick(1, 4'd2, 0);
    tick(1, 4'd3, 0);
    tick(1, 4'd4, 0);
    tick(1, 4'd5, 0);
    tick(1, 4'd6, 0);
    expect_eq("ovf_not_yet", 32'(overflow), 0);
    tick(1, 4'd7, 0);
    expect_eq("ovf_pulse", 32'(overflow), 1);
    expect_eq("ovf_head", 32'(out_letter), 1);
    tick(1, 4'd8, 1);
    expect_eq("ovf_pop_write", 32'(overflow), 0);
    expect_eq("ovf_pop_head", 32'(out_letter), 4);
    drain();

    // key 1 behaviour
    tick(1, 4'd5, 0);
    tick(1, 4'd1, 0);
`ifdef MULTITAP_BKSP_EN
    expect_eq("cancel_pend", 32'(pend_valid), 0);
    expect_eq("cancel_nowr", 32'(out_valid), 0);
    tick(1, 4'd1, 0);
    expect_eq("bksp_code", 32'(out_letter), 31);
`else
    expect_eq("confirm_pend", 32'(pend_valid), 0);
    expect_eq("confirm_code", 32'(out_letter), 10);
`endif
    drain();

    // reset mid-pending
    tick(1, 4'd6, 0);
    expect_eq("pre_rst_pend", 32'(pend_valid), 1);
    rst_n = 0;
    #1;
    expect_eq("in_rst_pend", 32'(pend_valid), 0);
    tick(0, 4'd0, 0);
    rst_n = 1;
    tick(0, 4'd0, 0);
    expect_eq("post_rst_pend", 32'(pend_valid), 0);
    expect_eq("post_rst_out", 32'(out_valid), 0);
    repeat (T + 2) tick(0, 4'd0, 0);
    expect_eq("no_stale", 32'(out_valid), 0);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 0;
        tick(0, 4'd0, 0);
        rst_n = 1;
      end else if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(4, 12)) tick(0, 4'd0, $urandom_range(0, 1));
      end else begin
        logic [3:0] kc;
        if ($urandom_range(0, 3) == 0) kc = 4'($urandom_range(0, 15));
        else kc = 4'($urandom_range(2, 4));
        tick($urandom_range(0, 2) == 0, kc, $urandom_range(0, 2) != 0);
      end
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks,
             n_errors);
    $finish;
  end

endmodule
